// File: rtl/usb_ctl_pipe0.sv
// EP0 control-transfer sequencer: captures the SETUP packet, presents it to
// the standard-request handler, streams the handler's IN data out as
// MAX_PACKET-sized packets and runs the status stage or a STALL.
module usb_ctl_pipe0 #(
  parameter int MAX_PACKET  = 64,
  parameter int GNT_TIMEOUT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        setup_i,
  input  logic [3:0]  setup_ep_i,
  input  logic        setup_tvalid_i,
  input  logic        setup_tlast_i,
  input  logic [7:0]  setup_tdata_i,
  input  logic        in_tok_i,
  input  logic        status_out_i,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        tx_tlast_o,
  output logic        tx_tkeep_o,
  output logic [7:0]  tx_tdata_o,
  output logic        stall_o,
  output logic [3:0]  ctl_xfer_endpoint_o,
  output logic [7:0]  ctl_xfer_type_o,
  output logic [7:0]  ctl_xfer_request_o,
  output logic [15:0] ctl_xfer_value_o,
  output logic [15:0] ctl_xfer_index_o,
  output logic [15:0] ctl_xfer_length_o,
  output logic        ctl_xfer_req_o,
  input  logic        ctl_xfer_gnt_i,
  input  logic        ctl_tvalid_i,
  output logic        ctl_tready_o,
  input  logic        ctl_tlast_i,
  input  logic [7:0]  ctl_tdata_i,
  output logic        busy_o
);

  // state      | meaning
  // S_IDLE     | no transfer in progress
  // S_SETUP_RX | collecting the 8 SETUP payload bytes
  // S_REQ      | request presented, waiting for handler grant
  // S_DATA_IN  | forwarding handler bytes as IN data packets
  // S_DATA_ZLP | data ended on a full packet, owe a zero-length packet
  // S_STATUS_OUT | waiting for host's zero-length OUT status
  // S_STATUS_IN  | sending our zero-length IN status
  // S_STALL    | no handler took the request, STALL until next SETUP
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP_RX, S_REQ, S_DATA_IN, S_DATA_ZLP,
    S_STATUS_OUT, S_STATUS_IN, S_STALL
  } state_t;

  localparam int WAIT_W = $clog2(GNT_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [3:0]        byte_cnt;
  logic [6:0][7:0]   shadow;
  logic [3:0]        ep_latch;
  logic [WAIT_W-1:0] wait_cnt;
  logic [6:0]        pkt_cnt;
  logic [15:0]       remaining;
  logic              pkt_open;

  logic setup_last, setup_done, setup_bad, timeout, gnt_data;
  logic data_phase, zlp_phase, pkt_full, last_data, data_xfer, zlp_xfer, open_pkt;

  assign setup_last = (state == S_SETUP_RX) && setup_tvalid_i && setup_tlast_i;
  assign setup_done = setup_last && (byte_cnt == 4'd7);
  assign setup_bad  = setup_last && (byte_cnt != 4'd7);
  assign timeout    = (wait_cnt == WAIT_W'(GNT_TIMEOUT));
  assign gnt_data   = ctl_xfer_type_o[7] && (ctl_xfer_length_o != 16'd0);
  assign data_phase = pkt_open && (state == S_DATA_IN);
  assign zlp_phase  = pkt_open && ((state == S_DATA_ZLP) || (state == S_STATUS_IN));
  assign pkt_full   = (pkt_cnt == 7'(MAX_PACKET - 1));
  assign last_data  = pkt_full || (remaining == 16'd1) || ctl_tlast_i;
  assign data_xfer  = data_phase && ctl_tvalid_i && tx_tready_i;
  assign zlp_xfer   = zlp_phase && tx_tready_i;
  // in_tok_i arriving while a packet is already open is simply ignored
  assign open_pkt   = !pkt_open && in_tok_i &&
                      ((state == S_DATA_IN) || (state == S_DATA_ZLP) || (state == S_STATUS_IN));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; a new SETUP token overrides everything
  always_comb begin
    state_nxt = state;
    if (setup_i) begin
      state_nxt = S_SETUP_RX;
    end else begin
      case (state)
        S_SETUP_RX: begin
          if (setup_done)     state_nxt = S_REQ;
          else if (setup_bad) state_nxt = S_IDLE;
        end
        S_REQ: begin
          if (ctl_xfer_gnt_i) state_nxt = gnt_data ? S_DATA_IN : S_STATUS_IN;
          else if (timeout)   state_nxt = S_STALL;
        end
        S_DATA_IN: begin
          if (data_xfer && last_data) begin
            if (remaining == 16'd1) state_nxt = S_STATUS_OUT;
            else if (ctl_tlast_i)   state_nxt = pkt_full ? S_DATA_ZLP : S_STATUS_OUT;
          end
        end
        S_DATA_ZLP:   if (zlp_xfer)     state_nxt = S_STATUS_OUT;
        S_STATUS_OUT: if (status_out_i) state_nxt = S_IDLE;
        S_STATUS_IN:  if (zlp_xfer)     state_nxt = S_IDLE;
        default:      state_nxt = state;
      endcase
    end
  end

  // Stream outputs: zero-latency pass-through for data, fixed ZLP otherwise
  always_comb begin
    tx_tvalid_o  = 1'b0;
    tx_tlast_o   = 1'b0;
    tx_tkeep_o   = 1'b0;
    tx_tdata_o   = 8'h00;
    ctl_tready_o = 1'b0;
    stall_o      = (state == S_STALL);
    busy_o       = (state != S_IDLE);
    if (data_phase) begin
      tx_tvalid_o  = ctl_tvalid_i;
      tx_tdata_o   = ctl_tdata_i;
      tx_tkeep_o   = 1'b1;
      tx_tlast_o   = last_data;
      ctl_tready_o = tx_tready_i;
    end else if (zlp_phase) begin
      tx_tvalid_o = 1'b1;
      tx_tlast_o  = 1'b1;
    end
  end

  // SETUP capture into shadow registers; request bus updated only on a clean 8-byte packet
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_cnt            <= 4'd0;
      shadow              <= '0;
      ep_latch            <= 4'd0;
      ctl_xfer_endpoint_o <= 4'd0;
      ctl_xfer_type_o     <= 8'h00;
      ctl_xfer_request_o  <= 8'h00;
      ctl_xfer_value_o    <= 16'h0000;
      ctl_xfer_index_o    <= 16'h0000;
      ctl_xfer_length_o   <= 16'h0000;
    end else if (setup_i) begin
      byte_cnt <= 4'd0;
      ep_latch <= setup_ep_i;
    end else if ((state == S_SETUP_RX) && setup_tvalid_i) begin
      if (byte_cnt < 4'd7) shadow[byte_cnt[2:0]] <= setup_tdata_i;
      if (byte_cnt != 4'd8) byte_cnt <= byte_cnt + 4'd1;
      if (setup_done) begin
        ctl_xfer_endpoint_o <= ep_latch;
        ctl_xfer_type_o     <= shadow[0];
        ctl_xfer_request_o  <= shadow[1];
        ctl_xfer_value_o    <= {shadow[3], shadow[2]};
        ctl_xfer_index_o    <= {shadow[5], shadow[4]};
        ctl_xfer_length_o   <= {setup_tdata_i, shadow[6]};
      end
    end
  end

  // Request line: rises after the copy, held until the status stage completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                          ctl_xfer_req_o <= 1'b0;
    else if (setup_i)                                   ctl_xfer_req_o <= 1'b0;
    else if (setup_done)                                ctl_xfer_req_o <= 1'b1;
    else if ((state == S_REQ) && !ctl_xfer_gnt_i && timeout) ctl_xfer_req_o <= 1'b0;
    else if ((state == S_STATUS_OUT) && status_out_i)   ctl_xfer_req_o <= 1'b0;
    else if ((state == S_STATUS_IN) && zlp_xfer)        ctl_xfer_req_o <= 1'b0;
  end

  // Grant wait counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          wait_cnt <= '0;
    else if (setup_done)                wait_cnt <= '0;
    else if ((state == S_REQ) && !timeout) wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Packet framing: open flag, in-packet byte count and bytes left of wLength
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_open  <= 1'b0;
      pkt_cnt   <= 7'd0;
      remaining <= 16'd0;
    end else if (setup_i) begin
      pkt_open <= 1'b0;
    end else begin
      if ((state == S_REQ) && ctl_xfer_gnt_i) remaining <= ctl_xfer_length_o;
      if (open_pkt) begin
        pkt_open <= 1'b1;
        pkt_cnt  <= 7'd0;
      end else if (data_xfer) begin
        pkt_cnt   <= pkt_cnt + 7'd1;
        remaining <= remaining - 16'd1;
        if (last_data) pkt_open <= 1'b0;
      end else if (zlp_xfer) begin
        pkt_open <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_ctl_pipe0.sv
// Directed bench for the EP0 control sequencer.
module tb_usb_ctl_pipe0;

  logic        clock = 1'b0;
  logic        reset;
  logic        setup_i;
  logic [3:0]  setup_ep_i;
  logic        setup_tvalid_i, setup_tlast_i;
  logic [7:0]  setup_tdata_i;
  logic        in_tok_i, status_out_i;
  logic        tx_tvalid_o, tx_tready_i, tx_tlast_o, tx_tkeep_o;
  logic [7:0]  tx_tdata_o;
  logic        stall_o;
  logic [3:0]  ctl_xfer_endpoint_o;
  logic [7:0]  ctl_xfer_type_o, ctl_xfer_request_o;
  logic [15:0] ctl_xfer_value_o, ctl_xfer_index_o, ctl_xfer_length_o;
  logic        ctl_xfer_req_o, ctl_xfer_gnt_i;
  logic        ctl_tvalid_i, ctl_tready_o, ctl_tlast_i;
  logic [7:0]  ctl_tdata_i;
  logic        busy_o;

  usb_ctl_pipe0 #(.MAX_PACKET(64), .GNT_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .setup_i(setup_i), .setup_ep_i(setup_ep_i),
    .setup_tvalid_i(setup_tvalid_i), .setup_tlast_i(setup_tlast_i), .setup_tdata_i(setup_tdata_i),
    .in_tok_i(in_tok_i), .status_out_i(status_out_i),
    .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i), .tx_tlast_o(tx_tlast_o),
    .tx_tkeep_o(tx_tkeep_o), .tx_tdata_o(tx_tdata_o), .stall_o(stall_o),
    .ctl_xfer_endpoint_o(ctl_xfer_endpoint_o), .ctl_xfer_type_o(ctl_xfer_type_o),
    .ctl_xfer_request_o(ctl_xfer_request_o), .ctl_xfer_value_o(ctl_xfer_value_o),
    .ctl_xfer_index_o(ctl_xfer_index_o), .ctl_xfer_length_o(ctl_xfer_length_o),
    .ctl_xfer_req_o(ctl_xfer_req_o), .ctl_xfer_gnt_i(ctl_xfer_gnt_i),
    .ctl_tvalid_i(ctl_tvalid_i), .ctl_tready_o(ctl_tready_o), .ctl_tlast_i(ctl_tlast_i),
    .ctl_tdata_i(ctl_tdata_i), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  int tests  = 0;
  int failed = 0;
  int hidx;

  typedef struct {
    logic [71:0] bytes;
    int          n;
    logic [3:0]  ep;
    logic        exp_req;
    logic [67:0] exp_fields;
  } setup_vec_t;

  setup_vec_t vecs[6];

  function automatic logic [67:0] fields();
    return {ctl_xfer_endpoint_o, ctl_xfer_type_o, ctl_xfer_request_o,
            ctl_xfer_value_o, ctl_xfer_index_o, ctl_xfer_length_o};
  endfunction

  function automatic logic [14:0] outs();
    return {tx_tvalid_o, tx_tlast_o, tx_tkeep_o, tx_tdata_o,
            stall_o, ctl_tready_o, busy_o, ctl_xfer_req_o};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the last byte was taken.
  task automatic send_setup(input logic [71:0] b, input int n, input logic [3:0] ep);
    setup_i = 1'b1;
    setup_ep_i = ep;
    @(negedge clock);
    setup_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      setup_tvalid_i = 1'b1;
      setup_tdata_i  = b[8*i +: 8];
      setup_tlast_i  = (i == n - 1);
      @(negedge clock);
    end
    setup_tvalid_i = 1'b0;
    setup_tlast_i  = 1'b0;
  endtask

  task automatic grant();
    ctl_xfer_gnt_i = 1'b1;
    @(negedge clock);
    ctl_xfer_gnt_i = 1'b0;
  endtask

  // Issue one IN token and play the handler: byte k = k*3+1, tlast on byte hlen-1.
  task automatic in_packet(input int hlen, output int got, output int last_at, output int bad);
    bit done;
    got = 0; last_at = 0; bad = 0; done = 1'b0;
    in_tok_i = 1'b1;
    @(negedge clock);
    in_tok_i = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      ctl_tvalid_i = (hidx < hlen);
      ctl_tdata_i  = 8'(hidx * 3 + 1);
      ctl_tlast_i  = (hidx == hlen - 1);
      tx_tready_i  = 1'b1;
      #1;
      if (tx_tvalid_o && tx_tready_i) begin
        got++;
        if (tx_tdata_o !== 8'(hidx * 3 + 1) || tx_tkeep_o !== 1'b1) bad++;
        if (tx_tlast_o) begin
          last_at = got;
          done = 1'b1;
        end
      end
      if (ctl_tready_o && ctl_tvalid_i) hidx++;
      @(negedge clock);
    end
    ctl_tvalid_i = 1'b0;
    ctl_tlast_i  = 1'b0;
    tx_tready_i  = 1'b0;
    if (!done) check("in_packet_timeout", 72'd0, 72'd1);
  endtask

  int got, last_at, bad;

  initial begin
    vecs[0] = '{72'h000040000001000680, 8, 4'h0, 1'b1, {4'h0, 8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040}};
    vecs[1] = '{72'h000000000000050500, 8, 4'h0, 1'b1, {4'h0, 8'h00, 8'h05, 16'h0005, 16'h0000, 16'h0000}};
    vecs[2] = '{72'h009ABC56781234A3C1, 8, 4'h5, 1'b1, {4'h5, 8'hC1, 8'hA3, 16'h1234, 16'h5678, 16'h9ABC}};
    vecs[3] = '{72'h000000DDCCBBAA0921, 6, 4'h9, 1'b0, {4'h5, 8'hC1, 8'hA3, 16'h1234, 16'h5678, 16'h9ABC}};
    vecs[4] = '{72'hEE0012000002000680, 9, 4'h3, 1'b0, {4'h5, 8'hC1, 8'hA3, 16'h1234, 16'h5678, 16'h9ABC}};
    vecs[5] = '{72'h000000000000000080, 1, 4'h1, 1'b0, {4'h5, 8'hC1, 8'hA3, 16'h1234, 16'h5678, 16'h9ABC}};

    reset = 1'b1;
    setup_i = 0; setup_ep_i = 0; setup_tvalid_i = 0; setup_tlast_i = 0; setup_tdata_i = 0;
    in_tok_i = 0; status_out_i = 0; tx_tready_i = 0; ctl_xfer_gnt_i = 0;
    ctl_tvalid_i = 0; ctl_tlast_i = 0; ctl_tdata_i = 0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 72'(outs()), 72'd0);
    check("reset_fields", 72'(fields()), 72'd0);
    reset = 1'b0;
    @(negedge clock);

    // SETUP decode table
    for (int v = 0; v < 6; v++) begin
      send_setup(vecs[v].bytes, vecs[v].n, vecs[v].ep);
      check($sformatf("vec%0d_req", v), 72'(ctl_xfer_req_o), 72'(vecs[v].exp_req));
      check($sformatf("vec%0d_busy", v), 72'(busy_o), 72'(vecs[v].exp_req));
      check($sformatf("vec%0d_fields", v), 72'(fields()), 72'(vecs[v].exp_fields));
    end

    // GET_DESCRIPTOR wLength=64, handler sends 18 bytes
    hidx = 0;
    send_setup(72'h000040000001000680, 8, 4'h0);
    check("t1_value", 72'(ctl_xfer_value_o), 72'h0100);
    check("t1_length", 72'(ctl_xfer_length_o), 72'h0040);
    grant();
    ctl_tvalid_i = 1'b1; tx_tready_i = 1'b1; #1;
    check("t1_no_tok", 72'({tx_tvalid_o, ctl_tready_o}), 72'd0);
    ctl_tvalid_i = 1'b0; tx_tready_i = 1'b0;
    in_packet(18, got, last_at, bad);
    check("t1_count", 72'(got), 72'd18);
    check("t1_last", 72'(last_at), 72'd18);
    check("t1_data", 72'(bad), 72'd0);
    check("t1_status_out", 72'({busy_o, ctl_xfer_req_o, tx_tvalid_o}), 72'b110);
    status_out_i = 1'b1; @(negedge clock); status_out_i = 1'b0;
    check("t1_done", 72'({busy_o, ctl_xfer_req_o}), 72'd0);

    // wLength=8 truncates a longer handler stream, no ZLP
    hidx = 0;
    send_setup(72'h000008000001000680, 8, 4'h0);
    grant();
    in_packet(20, got, last_at, bad);
    check("t2_count", 72'(got), 72'd8);
    check("t2_last", 72'(last_at), 72'd8);
    check("t2_data", 72'(bad), 72'd0);
    ctl_tvalid_i = 1'b1; tx_tready_i = 1'b1; in_tok_i = 1'b1;
    @(negedge clock);
    in_tok_i = 1'b0;
    @(negedge clock); #1;
    check("t2_after", 72'({ctl_tready_o, tx_tvalid_o, busy_o, ctl_xfer_req_o}), 72'b0011);
    ctl_tvalid_i = 1'b0; tx_tready_i = 1'b0;
    status_out_i = 1'b1; @(negedge clock); status_out_i = 1'b0;

    // wLength=0xFF, handler ends on exactly one full packet -> ZLP
    hidx = 0;
    send_setup(72'h0000FF000003000680, 8, 4'h0);
    grant();
    in_packet(64, got, last_at, bad);
    check("t3_count", 72'(got), 72'd64);
    check("t3_last", 72'(last_at), 72'd64);
    #1;
    check("t3_zlp_wait", 72'({tx_tvalid_o, busy_o}), 72'b01);
    in_tok_i = 1'b1; @(negedge clock); in_tok_i = 1'b0; #1;
    check("t3_zlp", 72'({tx_tvalid_o, tx_tlast_o, tx_tkeep_o}), 72'b110);
    tx_tready_i = 1'b1;
    @(negedge clock);
    tx_tready_i = 1'b0; #1;
    check("t3_status_out", 72'({busy_o, ctl_xfer_req_o, tx_tvalid_o}), 72'b110);
    status_out_i = 1'b1; @(negedge clock); status_out_i = 1'b0;
    check("t3_done", 72'({busy_o, ctl_xfer_req_o}), 72'd0);

    // wLength=70 with an endless handler: 64 + 6 split
    hidx = 0;
    send_setup(72'h000046000001000680, 8, 4'h0);
    grant();
    in_packet(100, got, last_at, bad);
    check("t4_pkt1", 72'({8'(got), 8'(last_at), 8'(bad)}), 72'h404000);
    in_packet(100, got, last_at, bad);
    check("t4_pkt2", 72'({8'(got), 8'(last_at), 8'(bad)}), 72'h060600);
    check("t4_status_out", 72'({busy_o, ctl_xfer_req_o, 8'(hidx)}), 72'h346);
    status_out_i = 1'b1; @(negedge clock); status_out_i = 1'b0;

    // SET_ADDRESS: status IN ZLP, req falls one cycle after the handshake
    send_setup(72'h000000000000050500, 8, 4'h0);
    grant();
    #1;
    check("t5_no_tok", 72'(tx_tvalid_o), 72'd0);
    in_tok_i = 1'b1; @(negedge clock); in_tok_i = 1'b0; #1;
    check("t5_zlp", 72'({tx_tvalid_o, tx_tlast_o, tx_tkeep_o, ctl_xfer_req_o}), 72'b1101);
    tx_tready_i = 1'b1; #1;
    check("t5_req_at_hs", 72'(ctl_xfer_req_o), 72'd1);
    @(negedge clock);
    tx_tready_i = 1'b0; #1;
    check("t5_req_after", 72'({ctl_xfer_req_o, busy_o, tx_tvalid_o}), 72'd0);

    // No grant -> STALL exactly GNT_TIMEOUT+1 cycles after req
    send_setup(72'h000002008100000C82, 8, 4'h0);
    repeat (4) @(negedge clock);
    check("t6_pre_stall", 72'({stall_o, ctl_xfer_req_o}), 72'b01);
    @(negedge clock);
    check("t6_stall", 72'({stall_o, ctl_xfer_req_o}), 72'b10);
    @(negedge clock);
    check("t6_stall_hold", 72'(stall_o), 72'd1);

    // Short SETUP clears the stall but leaves the request bus alone
    send_setup(72'h000000DDCCBBAA0921, 6, 4'h9);
    check("t7_state", 72'({stall_o, ctl_xfer_req_o, busy_o}), 72'd0);
    check("t7_fields", 72'(fields()),
          72'({4'h0, 8'h82, 8'h0C, 16'h0000, 16'h0081, 16'h0002}));

    // setup_i mid-packet aborts: req and tvalid drop on that edge
    send_setup(72'h000040000001000680, 8, 4'h0);
    grant();
    in_tok_i = 1'b1; @(negedge clock); in_tok_i = 1'b0;
    ctl_tvalid_i = 1'b1; tx_tready_i = 1'b0; #1;
    check("t8_open", 72'({tx_tvalid_o, ctl_xfer_req_o}), 72'b11);
    setup_i = 1'b1;
    @(negedge clock);
    setup_i = 1'b0; #1;
    check("t8_abort", 72'({ctl_xfer_req_o, tx_tvalid_o, busy_o}), 72'b001);
    ctl_tvalid_i = 1'b0;

    // Async reset mid-DATA_IN clears everything before any clock edge
    hidx = 0;
    send_setup(72'h000040000001000680, 8, 4'h0);
    grant();
    in_tok_i = 1'b1; @(negedge clock); in_tok_i = 1'b0;
    ctl_tvalid_i = 1'b1; ctl_tdata_i = 8'hA5; tx_tready_i = 1'b0; #1;
    check("t9_open", 72'({tx_tvalid_o, tx_tdata_o}), 72'h1A5);
    #1 reset = 1'b1;
    #1;
    check("t9_async_outs", 72'(outs()), 72'd0);
    check("t9_async_fields", 72'(fields()), 72'd0);
    @(negedge clock);
    reset = 1'b0;
    ctl_tvalid_i = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/usb_ctl_pipe0.md
Name: usb_ctl_pipe0

Overview:
Endpoint-0 control-transfer sequencer sitting directly upstream of the standard-request handler.
- Captures the 8-byte SETUP payload from the packet layer and decodes it onto the ctl_xfer_* request bus.
- Holds ctl_xfer_req_o through the entire transfer and waits for the handler's grant.
- Packetises the handler's byte stream into IN data packets, truncated to wLength and split at MAX_PACKET.
- Sequences the status stage and issues a STALL when no handler grants.

Parameters:
MAX_PACKET, 64, EP0 max packet size in bytes (8..64).
GNT_TIMEOUT, 4, cycles after req assertion to wait for ctl_xfer_gnt_i before stalling.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
setup_i  in  1  pulse: SETUP token accepted; latches setup_ep_i
setup_ep_i  in  4  endpoint number of SETUP token
setup_tvalid_i / setup_tlast_i  in  1/1  SETUP DATA0 payload stream (always ready)
setup_tdata_i  in  8  SETUP payload byte
in_tok_i  in  1  pulse: IN token on EP0, packet layer ready for one packet
status_out_i  in  1  pulse: zero-length OUT status packet received
tx_tvalid_o / tx_tready_i / tx_tlast_o  out/in/out  1  IN packet stream to packet layer
tx_tkeep_o  out  1  0 marks a zero-length packet (sent with tvalid & tlast)
tx_tdata_o  out  8  IN packet byte
stall_o  out  1  respond STALL to EP0 tokens
ctl_xfer_endpoint_o  out  4  latched endpoint
ctl_xfer_type_o / ctl_xfer_request_o  out  8/8  bmRequestType, bRequest
ctl_xfer_value_o / ctl_xfer_index_o / ctl_xfer_length_o  out  16 each  wValue, wIndex, wLength
ctl_xfer_req_o  out  1  request active
ctl_xfer_gnt_i  in  1  handler accepts request
ctl_tvalid_i / ctl_tready_o / ctl_tlast_i  in/out/in  1  handler data stream
ctl_tdata_i  in  8  handler byte
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async): state IDLE; all outputs 0, including every ctl_xfer_* field.

States:
- IDLE: on setup_i, go to SETUP_RX with byte count 0.
- SETUP_RX:
  - Byte order: byte0 type; byte1 request; bytes 2/3 value lo/hi; 4/5 index; 6/7 length (little-endian).
  - Fields are written into shadow registers. They are copied to ctl_xfer_* only when the 8th byte carries tlast.
  - Any other tlast position discards the SETUP and returns to IDLE with no req.
  - Bytes beyond the 8th are ignored.
- REQ:
  - ctl_xfer_req_o = 1 from the cycle after the copy.
  - Wait counter runs up to GNT_TIMEOUT; ctl_xfer_gnt_i is sampled every cycle.
  - Granted with type[7]=1 and length!=0: go to DATA_IN, remaining = length.
  - Granted otherwise: go to STATUS_IN.
  - Timeout: go to STALL.
- DATA_IN:
  - Idles until in_tok_i, then forwards one packet with tx_tdata_o = ctl_tdata_i and tx_tvalid_o = ctl_tvalid_i.
  - ctl_tready_o = tx_tready_i, only while a packet is open.
  - Zero-latency pass-through; no buffering. Retransmission on a missing ACK is the packet layer's job.
  - Per accepted byte: pkt_cnt+1, remaining-1.
  - tx_tlast_o = (pkt_cnt==MAX_PACKET-1) | (remaining==1) | ctl_tlast_i.
- After the last byte of a packet:
  - If remaining==0, go to STATUS_OUT.
  - Else if ctl_tlast_i ended it with a short packet, go to STATUS_OUT.
  - Else if ctl_tlast_i ended a full (MAX_PACKET) packet, go to DATA_ZLP.
  - Else stay in DATA_IN for the next in_tok_i.
- DATA_ZLP: on in_tok_i, send tvalid, tlast, tkeep=0; on handshake go to STATUS_OUT.
- STATUS_OUT: on status_out_i, drop req and return to IDLE.
- STATUS_IN: on in_tok_i, send a ZLP. On its handshake, drop req the next cycle and return to IDLE. The handler commits SET_ADDRESS/SET_CONFIG on req fall, so req must not fall before this handshake.
- STALL: stall_o=1 and req=0 until setup_i.

Boundary and ordering rules:
- setup_i in any state aborts the transfer: req drops the same edge, tx_tvalid_o drops, go to SETUP_RX. A new req needs at least one low cycle.
- tx_tkeep_o=1 for all data bytes.
- in_tok_i received while a packet is open is ignored.
- status_out_i received outside STATUS_OUT is ignored.

Test Plan:
- SETUP 80 06 00 01 00 00 40 00, grant next cycle, handler sends 18 bytes with tlast on the 18th, one in_tok_i -> ctl_xfer_value_o=0x0100 and length=0x0040; a single 18-byte packet with tx_tlast on byte 18; status_out_i -> req=0, IDLE.
- Same SETUP with wLength=0x0008 -> an 8-byte packet with tlast on byte 8; ctl_tready_o held 0 afterwards; no ZLP.
- wLength=0x00FF, handler supplies exactly 64 bytes with tlast -> one 64-byte packet, then a ZLP (tkeep=0) on the next in_tok_i, then STATUS_OUT.
- SET_ADDRESS 00 05 05 00 00 00 00 00 -> STATUS_IN; in_tok_i yields a ZLP; req falls exactly one cycle after the tx handshake.
- bRequest=0x0C, no grant -> stall_o=1 at GNT_TIMEOUT+1 cycles after req; next setup_i clears stall_o.
- 6-byte SETUP ending in tlast -> no req and ctl_xfer_* unchanged; async reset asserted mid-DATA_IN -> all outputs 0 immediately, without waiting for a clock edge.
